// File: rtl/memory_writeback.sv
// Write-side BRAM controller: buffers an upstream pixel stream in a small FIFO
// and writes it in raster order into the output BRAM while store_run_i is high.
module memory_writeback #(
  parameter int MAX_ROW    = 540,
  parameter int MAX_COL    = 540,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_run_i,
  output logic              store_done_o,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] d2mem_o,
  output logic [9:0]        cnt_img_row_o,
  output logic [9:0]        cnt_img_col_o
);

  // Handshake: upstream moves a pixel on a rising edge where valid_i && ready_o;
  // ready_o is registered and already reflects the occupancy after that edge.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ROW * MAX_COL - 1);
  localparam logic [9:0]        LAST_ROW  = 10'(MAX_ROW - 1);
  localparam logic [9:0]        LAST_COL  = 10'(MAX_COL - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [9:0]          row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0]   d2mem_q, d2mem_d;
  logic                ena_q, ena_d, wea_q, wea_d;
  logic                ready_q, ready_d, done_q, done_d;
  logic                push, pop, last_pop;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  assign push     = valid_i && ready_q;
  assign pop      = (state_q == RUN) && store_run_i && (count_q != '0);
  assign last_pop = pop && (addr_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    addr_d    = addr_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_addr_d = wr_addr_q;
    d2mem_d   = d2mem_q;
    ena_d     = pop;
    wea_d     = pop;

    if (pop) begin
      wr_addr_d = addr_q;
      d2mem_d   = fifo_mem[rd_ptr_q];
      addr_d    = addr_q + 1'b1;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: if (store_run_i) state_d = RUN;
      RUN: begin
        // The final pop also drops whatever is still buffered.
        if (last_pop) begin
          state_d  = DONE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      DONE: begin
        if (!store_run_i) begin
          state_d = IDLE;
          addr_d  = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (count_d != FULL_CNT) && (state_d != DONE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_addr_q <= '0;
      d2mem_q   <= '0;
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_addr_q <= wr_addr_d;
      d2mem_q   <= d2mem_d;
      ena_q     <= ena_d;
      wea_q     <= wea_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_i;
  end

  assign store_done_o  = done_q;
  assign ready_o       = ready_q;
  assign ena_o         = ena_q;
  assign wea_o         = wea_q;
  assign addr_o        = wr_addr_q;
  assign d2mem_o       = d2mem_q;
  assign cnt_img_row_o = row_q;
  assign cnt_img_col_o = col_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Bench for memory_writeback: a 4x4 instance driven by a vector table and
// hand sequences, plus a 3x5 instance with a 2-deep FIFO for frame boundaries.
module tb_memory_writeback;

  localparam int R = 4, C = 4, NPIX = R * C;
  localparam int BR = 3, BC = 5, BNPIX = BR * BC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        store_run_i = 1'b0, valid_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        store_done_o, ready_o, ena_o, wea_o;
  logic [18:0] addr_o;
  logic [7:0]  d2mem_o;
  logic [9:0]  cnt_img_row_o, cnt_img_col_o;

  logic        b_run = 1'b0, b_valid = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_done, b_ready, b_ena, b_wea;
  logic [18:0] b_addr;
  logic [7:0]  b_d2mem;
  logic [9:0]  b_row, b_col;

  int tests_run = 0, fails = 0, strobes = 0;
  logic [26:0] exp_q[$];
  logic [26:0] mon_e;

  typedef struct {
    int vmode;          // 0: continuous valid, 1: valid on every other cycle
    int start_delay;    // cycles with store_run_i low before the run starts
    int pause_next;     // pause when the next pixel to write is this index, -1 none
    int pause_len;
    int exp_idle_push;  // pushes accepted while held in IDLE
    int exp_prow, exp_pcol, exp_pstrobes;
    int exp_lat;        // handshake-to-strobe latency, -1 skip
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  memory_writeback #(.MAX_ROW(R), .MAX_COL(C), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .store_run_i(store_run_i), .store_done_o(store_done_o),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o), .ena_o(ena_o), .wea_o(wea_o),
    .addr_o(addr_o), .d2mem_o(d2mem_o), .cnt_img_row_o(cnt_img_row_o),
    .cnt_img_col_o(cnt_img_col_o)
  );

  memory_writeback #(.MAX_ROW(BR), .MAX_COL(BC), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .store_run_i(b_run), .store_done_o(b_done),
    .valid_i(b_valid), .data_i(b_data), .ready_o(b_ready), .ena_o(b_ena), .wea_o(b_wea),
    .addr_o(b_addr), .d2mem_o(b_d2mem), .cnt_img_row_o(b_row), .cnt_img_col_o(b_col)
  );

  function automatic logic [7:0] pix(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic preload(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({19'(i), pix(i)});
  endtask

  // Scoreboard: every strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (!rst && wea_o) begin
      int nxt;
      strobes++;
      check("strobe_ena", ena_o, 1);
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL strobe_unexpected: got addr %0d expected no strobe", addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", addr_o, mon_e[26:8]);
        check("strobe_data", d2mem_o, mon_e[7:0]);
      end
      nxt = (int'(addr_o) + 1) % NPIX;
      check("strobe_row", cnt_img_row_o, nxt / C);
      check("strobe_col", cnt_img_col_o, nxt % C);
      check("strobe_done", store_done_o, (addr_o == 19'(NPIX - 1)) ? 1 : 0);
      if (addr_o == 19'(NPIX - 1)) check("last_ready", ready_o, 0);
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    store_run_i = 1'b0; valid_i = 1'b0;
    b_run = 1'b0; b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_done", store_done_o, 0);
    check("rst_wea", wea_o, 0);
    check("rst_addr", addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", ready_o, 1);
    check("post_rst_b_ready", b_ready, 1);
  endtask

  task automatic run_frame(input vec_t v, input int abort_at);
    int sent = 0, hs0 = -1, st0 = -1, pause_left = 0;
    bit paused = 0, done_seen = 0;
    strobes = 0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      @(posedge clk);
      #1;
      store_run_i = (c >= v.start_delay);
      if (v.start_delay > 0 && c == v.start_delay) begin
        check("idle_pushes", sent, v.exp_idle_push);
        check("idle_ready", ready_o, 0);
        check("idle_strobes", strobes, 0);
      end
      if (v.pause_next >= 0 && !paused &&
          int'(cnt_img_row_o) * C + int'(cnt_img_col_o) == v.pause_next) begin
        paused = 1;
        pause_left = v.pause_len;
      end
      if (pause_left > 0) begin
        store_run_i = 1'b0;
        if (pause_left == 1) begin
          check("pause_strobes", strobes, v.exp_pstrobes);
          check("pause_row", cnt_img_row_o, v.exp_prow);
          check("pause_col", cnt_img_col_o, v.exp_pcol);
        end
        pause_left--;
      end
      valid_i = (sent < NPIX) && (v.vmode == 0 || (c % 2) == 0);
      data_i  = pix(sent);
      @(negedge clk);
      #1;
      if (valid_i && ready_o) begin
        if (hs0 < 0) hs0 = c;
        sent++;
      end
      if (wea_o && st0 < 0) st0 = c;
      if (store_done_o) done_seen = 1;
      if (abort_at >= 0 && strobes >= abort_at) return;
    end
    check("frame_done_seen", done_seen, 1);
    if (v.exp_lat >= 0) check("first_latency", st0 - hs0, v.exp_lat);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("done_hold", store_done_o, 1);
    check("done_no_write", wea_o, 0);
    check("done_ready", ready_o, 0);
    store_run_i = 1'b0;
    @(negedge clk);
    #1;
    check("idle_done_low", store_done_o, 0);
    check("idle_row", cnt_img_row_o, 0);
    check("idle_col", cnt_img_col_o, 0);
    check("idle_ready_back", ready_o, 1);
    check("frame_strobes", strobes, NPIX);
    check("frame_exp_left", exp_q.size(), 0);
    check("frame_sent", sent, NPIX);
  endtask

  initial begin
    vecs[0] = '{vmode: 0, start_delay: 0, pause_next: -1, pause_len: 0, exp_idle_push: 0,
                exp_prow: 0, exp_pcol: 0, exp_pstrobes: 0, exp_lat: 2};
    vecs[1] = '{vmode: 0, start_delay: 8, pause_next: -1, pause_len: 0, exp_idle_push: 4,
                exp_prow: 0, exp_pcol: 0, exp_pstrobes: 0, exp_lat: -1};
    vecs[2] = '{vmode: 0, start_delay: 0, pause_next: 7, pause_len: 5, exp_idle_push: 0,
                exp_prow: 1, exp_pcol: 3, exp_pstrobes: 7, exp_lat: 2};
    vecs[3] = '{vmode: 1, start_delay: 0, pause_next: -1, pause_len: 0, exp_idle_push: 0,
                exp_prow: 0, exp_pcol: 0, exp_pstrobes: 0, exp_lat: 2};

    for (int i = 0; i < 4; i++) begin
      apply_reset();
      preload(NPIX);
      run_frame(vecs[i], -1);
    end

    // Asynchronous reset in the middle of a frame, then a clean frame.
    apply_reset();
    preload(10);
    run_frame(vecs[0], 10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ena", ena_o, 0);
    check("arst_wea", wea_o, 0);
    check("arst_addr", addr_o, 0);
    check("arst_data", d2mem_o, 0);
    check("arst_ready", ready_o, 0);
    check("arst_done", store_done_o, 0);
    check("arst_row", cnt_img_row_o, 0);
    check("arst_col", cnt_img_col_o, 0);
    check("arst_exp_left", exp_q.size(), 0);
    store_run_i = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    preload(NPIX);
    run_frame(vecs[0], -1);

    // Non-square frame with a 2-entry FIFO.
    begin
      int bsent = 0, bi = 0, nxt;
      bit bdone = 0;
      b_run = 1'b1;
      for (int c = 0; c < 200 && !bdone; c++) begin
        @(posedge clk);
        #1;
        b_valid = (bsent < BNPIX);
        b_data  = pix(bsent);
        @(negedge clk);
        #1;
        if (b_valid && b_ready) bsent++;
        if (b_wea) begin
          nxt = (bi + 1) % BNPIX;
          check("b_addr", b_addr, bi);
          check("b_data", b_d2mem, pix(bi));
          check("b_row", b_row, nxt / BC);
          check("b_col", b_col, nxt % BC);
          check("b_done_edge", b_done, (bi == BNPIX - 1) ? 1 : 0);
          bi++;
        end
        if (b_done) bdone = 1;
      end
      check("b_strobe_count", bi, BNPIX);
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      b_run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("b_idle_done", b_done, 0);
      check("b_idle_row", b_row, 0);
      check("b_idle_col", b_col, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
